uart_rx_fifo: RTL and testbench

Receive-side buffer between the UART receiver and the CPU load path. Captures every byte the UART flags as received into a DEPTH-entry FIFO, so back-to-back serial frames are not lost while the CPU is busy. Exposes a show-ahead data register and a status/control register in the memory-mapped I/O window. Raises a level interrupt request toward the CPU's interrupt logic.

---
 rtl/uart_rx_fifo_pkg.sv | 30 +++
 rtl/uart_rx_fifo_if.sv | 19 +
 rtl/uart_rx_fifo_core.sv | 73 +++++++
 rtl/uart_rx_fifo.sv | 136 +++++++++++++
 tb/tb_uart_rx_fifo.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants and types for the UART receive FIFO block.
// Holds the I/O address map, status/control bit positions and the status word layout.
package uart_rx_fifo_pkg;

  localparam int unsigned DEPTH_DEF          = 16;
  localparam int unsigned PTR_W_DEF          = 4;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;

  // I/O window addresses shared with the computer and UART blocks.
  localparam logic [7:0] DATA_ADDR_DEF = 8'd248;
  localparam logic [7:0] STAT_ADDR_DEF = 8'd247;

  // Control word bit positions (write to STAT_ADDR).
  localparam int unsigned CTRL_FLUSH_BIT   = 6;
  localparam int unsigned CTRL_CLR_OVF_BIT = 7;

  // Status word (read from STAT_ADDR), MSB first.
  typedef struct packed {
    logic       int_req;
    logic       overflow;
    logic       full;
    logic [4:0] count;
  } status_t;

  // Status count field saturates at 31 for deep FIFOs.
  function automatic logic [4:0] sat_count5(input int unsigned c);
    return (c > 31) ? 5'd31 : 5'(c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// CPU-side memory-mapped access bus of the UART receive FIFO.
// master = CPU load/store path, slave = the FIFO register block.
interface uart_rx_fifo_if;
  logic [7:0] access_addr;
  logic [7:0] wr_data;
  logic       mem_w_en;
  logic       reg_w_en;
  logic [7:0] rd_data;

  modport master (
    output access_addr, wr_data, mem_w_en, reg_w_en,
    input  rd_data
  );

  modport slave (
    input  access_addr, wr_data, mem_w_en, reg_w_en,
    output rd_data
  );
endinterface

// File: rtl/uart_rx_fifo_core.sv
// sync_fifo_core: storage, pointers and occupancy of the receive FIFO.
// Resolves push/pop/flush in one place; a push into a full FIFO is only
// accepted when a pop frees a slot in the same cycle.
module sync_fifo_core #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PTR_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [7:0]       wdata,
  output logic [7:0]       head,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty,
  output logic             push_ok,
  output logic             pop_ok,
  output logic             overflow_evt
);

  localparam int unsigned CNT_W = PTR_W + 1;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Resolve which requests actually take effect this cycle.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    pop_ok       = 1'b0;
    push_ok      = 1'b0;
    overflow_evt = 1'b0;
    if (!flush) begin
      pop_ok       = pop & ~empty;
      push_ok      = push & (~full | pop_ok);
      overflow_evt = push & full & ~pop_ok;
    end
  end

  // Data storage; written only on an accepted push.
  // NOTE: the memory array has no reset; contents are don't-care until written, which keeps it RAM-mappable.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop_ok)      count <= count + CNT_W'(1);
      else if (pop_ok && !push_ok) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer between the UART and the CPU load path.
// Edge-detects receive_flag into pushes, exposes a show-ahead data register
// and a status/control register, and drives a level interrupt request.
// Optional idle timeout interrupt: define UART_RX_FIFO_TIMEOUT_EN.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH          = DEPTH_DEF,
  parameter int unsigned PTR_W          = PTR_W_DEF,
  parameter logic [7:0]  DATA_ADDR      = DATA_ADDR_DEF,
  parameter logic [7:0]  STAT_ADDR      = STAT_ADDR_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic [7:0]     rx_data,
  input  logic           receive_flag,
  uart_rx_fifo_if.slave  bus,
  output logic           int_req,
  output logic           overflow
);

  localparam int unsigned CNT_W = PTR_W + 1;

  logic             rf_q;
  logic             push;
  logic             data_sel;
  logic             stat_sel;
  logic             pop_req;
  logic             ctrl_we;
  logic             flush;
  logic [7:0]       head;
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;
  logic             push_ok;
  logic             pop_ok;
  logic             overflow_evt;
  logic [PTR_W:0]   threshold;
  logic [PTR_W:0]   threshold_new;
  logic             timeout_flag;
  logic             ctrl_unused;
  status_t          status;

  assign push     = receive_flag & ~rf_q;
  assign data_sel = (bus.access_addr == DATA_ADDR);
  assign stat_sel = (bus.access_addr == STAT_ADDR);
  assign pop_req  = bus.reg_w_en & data_sel;
  assign ctrl_we  = bus.mem_w_en & stat_sel;
  assign flush    = ctrl_we & bus.wr_data[CTRL_FLUSH_BIT];

  // Bit 5 of the control word has no function.
  assign ctrl_unused = bus.wr_data[5];

  // Threshold field clamped to the FIFO depth.
  assign threshold_new = (int'(bus.wr_data[4:0]) > int'(DEPTH)) ? CNT_W'(DEPTH)
                                                                 : CNT_W'(bus.wr_data[4:0]);

  sync_fifo_core #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_core (
    .clock        (clock),
    .reset_n      (reset_n),
    .push         (push),
    .pop          (pop_req),
    .flush        (flush),
    .wdata        (rx_data),
    .head         (head),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .push_ok      (push_ok),
    .pop_ok       (pop_ok),
    .overflow_evt (overflow_evt)
  );

  // Edge detector, sticky overflow flag and threshold register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rf_q      <= 1'b0;
      overflow  <= 1'b0;
      threshold <= '0;
    end else begin
      rf_q <= receive_flag;
      if (overflow_evt)                                    overflow <= 1'b1;
      else if (ctrl_we && bus.wr_data[CTRL_CLR_OVF_BIT])   overflow <= 1'b0;
      if (ctrl_we) threshold <= threshold_new;
    end
  end

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt;

  // Idle counter: runs while data waits, restarts on any FIFO activity.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      to_cnt       <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (push_ok || pop_ok || flush || empty) to_cnt <= '0;
      else if (to_cnt != TO_LAST)              to_cnt <= to_cnt + TO_W'(1);

      if (pop_ok || flush || empty)            timeout_flag <= 1'b0;
      else if (!push_ok && to_cnt == TO_LAST)  timeout_flag <= 1'b1;
    end
  end
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT_CYCLES == 0);
  assign timeout_flag   = 1'b0;
`endif

  assign int_req = ((threshold != '0) && (count >= threshold)) || timeout_flag;

  assign status = '{
    int_req:  int_req,
    overflow: overflow,
    full:     full,
    count:    sat_count5(int'(count))
  };

  // CPU read mux: show-ahead head byte or status word, zero elsewhere.
  always_comb begin
    bus.rd_data = 8'h00;
    if (data_sel) begin
      if (!empty) bus.rd_data = head;
    end else if (stat_sel) begin
      bus.rd_data = status;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16).
// With UART_RX_FIFO_TIMEOUT_EN defined the DUT is built with TIMEOUT_CYCLES=8.
module tb_uart_rx_fifo;

  localparam logic [7:0] DATA_A = 8'd248;
  localparam logic [7:0] STAT_A = 8'd247;
`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam int unsigned TO_CYC = 8;
`else
  localparam int unsigned TO_CYC = 1024;
`endif

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] rx_data;
  logic       receive_flag;
  logic       int_req;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx_fifo_if bus ();

  uart_rx_fifo #(
    .DEPTH          (16),
    .PTR_W          (4),
    .DATA_ADDR      (DATA_A),
    .STAT_ADDR      (STAT_A),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .rx_data      (rx_data),
    .receive_flag (receive_flag),
    .bus          (bus),
    .int_req      (int_req),
    .overflow     (overflow)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // One rising edge of receive_flag, then drop it again.
  task automatic push_byte(input logic [7:0] b);
    rx_data      = b;
    receive_flag = 1'b1;
    step();
    receive_flag = 1'b0;
    step();
  endtask

  task automatic check_status(input string tag, input logic [7:0] exp);
    bus.access_addr = STAT_A;
    #1;
    check(tag, bus.rd_data, exp);
  endtask

  // Check the show-ahead head byte, then pop it.
  task automatic pop_check(input string tag, input logic [7:0] exp);
    bus.access_addr = DATA_A;
    #1;
    check(tag, bus.rd_data, exp);
    bus.reg_w_en = 1'b1;
    step();
    bus.reg_w_en = 1'b0;
  endtask

  task automatic ctrl_write(input logic [7:0] v);
    bus.access_addr = STAT_A;
    bus.wr_data     = v;
    bus.mem_w_en    = 1'b1;
    step();
    bus.mem_w_en    = 1'b0;
  endtask

  initial begin
    reset_n         = 1'b0;
    rx_data         = 8'h00;
    receive_flag    = 1'b0;
    bus.access_addr = 8'h00;
    bus.wr_data     = 8'h00;
    bus.mem_w_en    = 1'b0;
    bus.reg_w_en    = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();

    // Reset state.
    check("rst_int_req", {7'd0, int_req}, 8'h00);
    check("rst_overflow", {7'd0, overflow}, 8'h00);
    check_status("rst_status", 8'h00);
    bus.access_addr = DATA_A;
    #1;
    check("rst_data_empty", bus.rd_data, 8'h00);

    // Three bytes in, three out in order, then empty read.
    push_byte(8'h41);
    push_byte(8'h42);
    push_byte(8'h43);
    check_status("three_status", 8'h03);
    pop_check("pop_41", 8'h41);
    pop_check("pop_42", 8'h42);
    pop_check("pop_43", 8'h43);
    pop_check("pop_empty", 8'h00);
    check_status("empty_after_pop", 8'h00);

    // Seventeen pushes: sixteen kept, one dropped with overflow.
    for (int i = 0; i < 17; i++) push_byte(8'h10 + 8'(i));
    check_status("full_ovf_status", 8'h70);
    check("ovf_pin", {7'd0, overflow}, 8'h01);
    bus.access_addr = 8'h10;
    #1;
    check("other_addr_zero", bus.rd_data, 8'h00);
    for (int i = 0; i < 16; i++) pop_check("drain_full", 8'h10 + 8'(i));
    check_status("drained_status", 8'h40);
    ctrl_write(8'h80);
    check_status("ovf_cleared", 8'h00);

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
    check_status("refill_status", 8'h30);
    bus.access_addr = DATA_A;
    rx_data         = 8'hAA;
    receive_flag    = 1'b1;
    bus.reg_w_en    = 1'b1;
    step();
    receive_flag    = 1'b0;
    bus.reg_w_en    = 1'b0;
    check_status("pushpop_full_status", 8'h30);
    for (int i = 1; i < 16; i++) pop_check("pushpop_drain", 8'h20 + 8'(i));
    pop_check("pushpop_last", 8'hAA);
    check_status("pushpop_empty", 8'h00);

    // Threshold interrupt at four entries.
    ctrl_write(8'h04);
    push_byte(8'h31);
    push_byte(8'h32);
    push_byte(8'h33);
    check("thr_below", {7'd0, int_req}, 8'h00);
    rx_data      = 8'h34;
    receive_flag = 1'b1;
    step();
    check("thr_reached", {7'd0, int_req}, 8'h01);
    check_status("thr_status", 8'h84);
    receive_flag = 1'b0;
    step();
    pop_check("thr_pop", 8'h31);
    check("thr_cleared", {7'd0, int_req}, 8'h00);
    pop_check("thr_pop2", 8'h32);
    pop_check("thr_pop3", 8'h33);
    pop_check("thr_pop4", 8'h34);

    // Level held high for ten cycles gives one push.
    rx_data      = 8'h55;
    receive_flag = 1'b1;
    repeat (10) step();
    receive_flag = 1'b0;
    step();
    check_status("held_one_push", 8'h01);

    // Flush with a simultaneous push discards everything.
    rx_data         = 8'h66;
    receive_flag    = 1'b1;
    bus.access_addr = STAT_A;
    bus.wr_data     = 8'h40;
    bus.mem_w_en    = 1'b1;
    step();
    bus.mem_w_en    = 1'b0;
    receive_flag    = 1'b0;
    step();
    check_status("flush_status", 8'h00);
    push_byte(8'h77);
    check_status("post_flush_status", 8'h01);
    pop_check("post_flush_pop", 8'h77);

    // Idle timeout (or its absence in the default build).
    push_byte(8'h5A);
`ifdef UART_RX_FIFO_TIMEOUT_EN
    repeat (6) step();
    check("to_not_yet", {7'd0, int_req}, 8'h00);
    step();
    check("to_fired", {7'd0, int_req}, 8'h01);
`else
    repeat (20) step();
    check("no_timeout", {7'd0, int_req}, 8'h00);
`endif
    pop_check("to_pop", 8'h5A);
    check("to_cleared", {7'd0, int_req}, 8'h00);

    // Reset during a burst discards buffered data.
    push_byte(8'h88);
    push_byte(8'h99);
    reset_n      = 1'b0;
    rx_data      = 8'hEE;
    receive_flag = 1'b1;
    step();
    step();
    receive_flag = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    check_status("midreset_status", 8'h00);
    bus.access_addr = DATA_A;
    #1;
    check("midreset_data", bus.rd_data, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
